motoro3_step_sequencer: RTL and testbench
=========================================

# motoro3_step_sequencer

Timing and commutation controller for one motoro3 drive channel. It generates the period counter `m3cnt` with its first/last strobes, the 6-step commutation index `lgStep`, the PWM split sub-step index and the PWM activity flags. The line generator and PWM generator consume these outputs directly. The block supports start, graceful stop and immediate fault abort.

## Interface
Parameters:
- `STEP_NUM`, 6: commutation steps per electrical revolution; the step index runs 0..`STEP_NUM`-1.
- `IDLE_STEP`, 4'hF: `lgStep` code driven while idle; the MOS driver decodes it as all-off.
- `CNT_MIN`, 4: minimum period length; smaller speed settings are clamped up to this value.

Ports:
- `clk` in 1: system clock, 10 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `m3start` in 1: level run request. Rising into RUN starts sequencing; deasserting requests a graceful stop.
- `m3fault` in 1: immediate abort, level.
- `m3r_stepCNT_speedSET` in 25: period length in clocks.
- `m3r_stepSplitMax` in 2: last split sub-step index; each step has `m3r_stepSplitMax`+1 periods.
- `m3cnt` out 25: period counter.
- `m3cntFirst1` out 1: high when `m3cnt`==0.
- `m3cntFirst2` out 1: high when `m3cnt`==1.
- `m3cntLast1` out 1: high when `m3cnt`==period-1.
- `m3cntLast2` out 1: high when `m3cnt`==period-2.
- `lgStep` out 4: commutation step index.
- `m3LpwmSplitStep` out 2: current split sub-step.
- `pwmActive1` out 1: high while the state is RUN or STOPPING.
- `pwmLastStep1` out 1: high during the final split sub-step of the current step.
- `m3busy` out 1: high when the state is not IDLE.

## Operation
- States are IDLE, RUN, STOPPING and FAULT.
- IDLE:
  - `m3cnt`=0, all strobes 0, `lgStep`=`IDLE_STEP`, split=0.
  - `m3start`=1 with `m3fault`=0 moves to RUN.
- RUN:
  - `m3cnt` increments every clock and wraps to 0 after period-1.
  - The period is latched from `m3r_stepCNT_speedSET` at each wrap and at RUN entry. Mid-period changes have no effect until the next wrap.
  - Latched period = max(`m3r_stepCNT_speedSET`, `CNT_MIN`).
  - At each wrap, split increments. When split==latched `m3r_stepSplitMax`, split instead returns to 0 and `lgStep` advances (`STEP_NUM`-1 goes to 0).
  - `m3r_stepSplitMax` is latched together with the period.
  - `m3start`=0 moves to STOPPING.
- STOPPING:
  - Sequencing continues until the wrap that would advance `lgStep`; that wrap goes to IDLE instead.
  - `m3start`=1 again during STOPPING returns to RUN with no disturbance to the counters.
- FAULT:
  - `m3fault`=1 in any state enters FAULT on the next clock, with outputs at their IDLE values.
  - FAULT exits to IDLE only when `m3fault`=0 and `m3start`=0.
- Simultaneous events:
  - Fault beats start and beats wrap.
  - Stop and wrap in the same cycle: the wrap is processed first, then the state becomes STOPPING.
- `pwmLastStep1` = (split == latched `m3r_stepSplitMax`) while RUN or STOPPING, else 0.

## Timing
- All outputs are registered.
- Every strobe is asserted in the same cycle as the `m3cnt` value it describes.
- Start to first output: 1 clock. `m3start` sampled high at edge N gives, at edge N+1, `lgStep`=0, `m3cnt`=0, `m3cntFirst1`=1, `pwmActive1`=1.
- Fault to off: 1 clock. `m3fault` sampled at edge N gives `lgStep`=`IDLE_STEP` and `pwmActive1`=0 at N+1.
- With period P:
  - `m3cntLast2` is high at `m3cnt`=P-2.
  - `m3cntLast1` is high at `m3cnt`=P-1.
  - Strobes for different positions never coincide because P≥4.
- Reset values: `m3cnt`=0, all strobes 0, `lgStep`=`IDLE_STEP`, `m3LpwmSplitStep`=0, `pwmActive1`=0, `pwmLastStep1`=0, `m3busy`=0, state=IDLE.
- Reset asserted mid-run forces these values immediately (asynchronous) and holds them while `rst`=1.

## Configuration
- `M3SEQ_REVERSE_EN` defined:
  - Adds input `m3r_dirReverse` (1 bit), latched together with the period.
  - When 1, `lgStep` decrements at each step advance (0 goes to `STEP_NUM`-1).
  - The first RUN step is still 0.
- Not defined: the port is absent and `lgStep` always increments.

## Test plan
- Reset, then `m3start`=1, speed=10, splitMax=0 -> `lgStep` sequence 0,1,2,3,4,5,0 with steps 10 clocks apart; First1 at `m3cnt`=0, Last2 at 8, Last1 at 9.
- speed=2 -> period clamped to 4; `m3cnt` cycles 0..3; `pwmLastStep1`=1 continuously.
- splitMax=2, speed=5 -> split cycles 0,1,2 every 5 clocks; `lgStep` advances every 15 clocks; `pwmLastStep1` high only during split 2.
- `m3start` dropped at `m3cnt`=3 of step 2 (speed=10, splitMax=0) -> step 2 completes through `m3cnt`=9, then IDLE: `lgStep`=F, `pwmActive1`=0, `m3busy`=0.
- `m3fault` pulsed mid-run -> `lgStep`=F one clock later; `m3start` held at 1 keeps the block in FAULT; it returns to IDLE only after both inputs are 0.
- With `M3SEQ_REVERSE_EN` and `m3r_dirReverse`=1 -> `lgStep` sequence 0,5,4,3,2,1,0.

Source files
------------

// File: rtl/motoro3_step_sequencer_if.sv
// Configuration and status bundle between a motoro3 channel controller and its step sequencer.
// M3SEQ_REVERSE_EN adds the m3r_dirReverse direction select.
interface motoro3_step_sequencer_if;
  logic        m3start;
  logic        m3fault;
  logic [24:0] m3r_stepCNT_speedSET;
  logic [1:0]  m3r_stepSplitMax;
`ifdef M3SEQ_REVERSE_EN
  logic        m3r_dirReverse;
`endif
  logic [24:0] m3cnt;
  logic        m3cntFirst1;
  logic        m3cntFirst2;
  logic        m3cntLast1;
  logic        m3cntLast2;
  logic [3:0]  lgStep;
  logic [1:0]  m3LpwmSplitStep;
  logic        pwmActive1;
  logic        pwmLastStep1;
  logic        m3busy;

  modport master (
`ifdef M3SEQ_REVERSE_EN
    output m3r_dirReverse,
`endif
    output m3start, m3fault, m3r_stepCNT_speedSET, m3r_stepSplitMax,
    input  m3cnt, m3cntFirst1, m3cntFirst2, m3cntLast1, m3cntLast2,
    input  lgStep, m3LpwmSplitStep, pwmActive1, pwmLastStep1, m3busy
  );

  modport slave (
`ifdef M3SEQ_REVERSE_EN
    input  m3r_dirReverse,
`endif
    input  m3start, m3fault, m3r_stepCNT_speedSET, m3r_stepSplitMax,
    output m3cnt, m3cntFirst1, m3cntFirst2, m3cntLast1, m3cntLast2,
    output lgStep, m3LpwmSplitStep, pwmActive1, pwmLastStep1, m3busy
  );
endinterface

// File: rtl/motoro3_step_sequencer.sv
// Period counter, split sub-step and 6-step commutation sequencer for one motoro3 channel.
// M3SEQ_REVERSE_EN adds a latched direction input that makes lgStep count down.
module motoro3_step_sequencer #(
  parameter int unsigned STEP_NUM  = 6,
  parameter logic [3:0]  IDLE_STEP = 4'hF,
  parameter logic [24:0] CNT_MIN   = 25'd4
) (
  input logic clk,
  input logic rst,
  motoro3_step_sequencer_if.slave seq
);
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2,
    S_FAULT    = 2'd3
  } state_e;

  localparam logic [3:0] LAST_STEP = 4'(STEP_NUM - 1);

  state_e      state_q, state_d;
  logic [24:0] cnt_q, cnt_d;
  logic [24:0] period_q, period_d;
  logic [1:0]  split_q, split_d;
  logic [1:0]  split_max_q, split_max_d;
  logic [3:0]  step_q, step_d;
  logic        first1_q, first1_d;
  logic        first2_q, first2_d;
  logic        last1_q, last1_d;
  logic        last2_q, last2_d;
  logic        active_q, active_d;
  logic        last_step_q, last_step_d;
  logic        busy_q, busy_d;
  logic        dir_rev_q, dir_rev_d;
  logic        dir_rev_in;

  logic [24:0] period_in;
  logic        wrap;
  logic        advance;
  logic [3:0]  step_next;

`ifdef M3SEQ_REVERSE_EN
  assign dir_rev_in = seq.m3r_dirReverse;
`else
  assign dir_rev_in = 1'b0;
`endif

  assign period_in = (seq.m3r_stepCNT_speedSET < CNT_MIN) ? CNT_MIN : seq.m3r_stepCNT_speedSET;
  assign wrap      = (cnt_q == period_q - 25'd1);
  assign advance   = wrap && (split_q == split_max_q);

  // Direction used for an advance is the one latched with the period now ending.
  always_comb begin
    step_next = step_q + 4'd1;
    if (dir_rev_q) begin
      step_next = (step_q == 4'd0) ? LAST_STEP : step_q - 4'd1;
    end else if (step_q == LAST_STEP) begin
      step_next = 4'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    split_d     = split_q;
    split_max_d = split_max_q;
    step_d      = step_q;
    dir_rev_d   = dir_rev_q;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        split_d = '0;
        step_d  = IDLE_STEP;
        if (seq.m3start) begin
          state_d     = S_RUN;
          period_d    = period_in;
          split_max_d = seq.m3r_stepSplitMax;
          dir_rev_d   = dir_rev_in;
          step_d      = 4'd0;
        end
      end
      S_RUN, S_STOPPING: begin
        cnt_d = wrap ? '0 : cnt_q + 25'd1;
        if (wrap) begin
          period_d    = period_in;
          split_max_d = seq.m3r_stepSplitMax;
          dir_rev_d   = dir_rev_in;
          if (advance) begin
            split_d = '0;
            step_d  = step_next;
          end else begin
            split_d = split_q + 2'd1;
          end
        end
        // A graceful stop ends on the wrap that would start a new step.
        if (seq.m3start) begin
          state_d = S_RUN;
        end else if (state_q == S_STOPPING && advance) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          split_d = '0;
          step_d  = IDLE_STEP;
        end else begin
          state_d = S_STOPPING;
        end
      end
      S_FAULT: begin
        cnt_d   = '0;
        split_d = '0;
        step_d  = IDLE_STEP;
        if (!seq.m3start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (seq.m3fault) begin
      state_d = S_FAULT;
      cnt_d   = '0;
      split_d = '0;
      step_d  = IDLE_STEP;
    end
  end

  always_comb begin
    active_d    = (state_d == S_RUN) || (state_d == S_STOPPING);
    busy_d      = (state_d != S_IDLE);
    first1_d    = active_d && (cnt_d == 25'd0);
    first2_d    = active_d && (cnt_d == 25'd1);
    last1_d     = active_d && (cnt_d == period_d - 25'd1);
    last2_d     = active_d && (cnt_d == period_d - 25'd2);
    last_step_d = active_d && (split_d == split_max_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      period_q    <= CNT_MIN;
      split_q     <= '0;
      split_max_q <= '0;
      step_q      <= IDLE_STEP;
      dir_rev_q   <= 1'b0;
      first1_q    <= 1'b0;
      first2_q    <= 1'b0;
      last1_q     <= 1'b0;
      last2_q     <= 1'b0;
      active_q    <= 1'b0;
      last_step_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      split_q     <= split_d;
      split_max_q <= split_max_d;
      step_q      <= step_d;
      dir_rev_q   <= dir_rev_d;
      first1_q    <= first1_d;
      first2_q    <= first2_d;
      last1_q     <= last1_d;
      last2_q     <= last2_d;
      active_q    <= active_d;
      last_step_q <= last_step_d;
      busy_q      <= busy_d;
    end
  end

  assign seq.m3cnt           = cnt_q;
  assign seq.m3cntFirst1     = first1_q;
  assign seq.m3cntFirst2     = first2_q;
  assign seq.m3cntLast1      = last1_q;
  assign seq.m3cntLast2      = last2_q;
  assign seq.lgStep          = step_q;
  assign seq.m3LpwmSplitStep = split_q;
  assign seq.pwmActive1      = active_q;
  assign seq.pwmLastStep1    = last_step_q;
  assign seq.m3busy          = busy_q;
endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed bench for motoro3_step_sequencer with a cycle model checked on every falling edge.
// Build with M3SEQ_REVERSE_EN defined to also exercise reverse commutation.
module tb_motoro3_step_sequencer;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  motoro3_step_sequencer_if ifc ();

  motoro3_step_sequencer dut (
    .clk (clk),
    .rst (rst),
    .seq (ifc.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Model state: mode 0 idle, 1 run, 2 stopping, 3 fault.
  int m_mode, m_cnt, m_per, m_smax, m_split, m_step, m_dir;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_per = 4; m_smax = 0; m_split = 0; m_step = 0; m_dir = 0;
  endtask

  function automatic int clamp_speed(input int s);
    return (s < 4) ? 4 : s;
  endfunction

  task automatic model_latch();
    m_per  = clamp_speed(int'(ifc.m3r_stepCNT_speedSET));
    m_smax = int'(ifc.m3r_stepSplitMax);
`ifdef M3SEQ_REVERSE_EN
    m_dir  = int'(ifc.m3r_dirReverse);
`else
    m_dir  = 0;
`endif
  endtask

  task automatic model_step();
    bit adv;
    if (ifc.m3fault) begin
      m_mode = 3;
      return;
    end
    case (m_mode)
      0: if (ifc.m3start) begin
        m_mode = 1; m_cnt = 0; m_split = 0; m_step = 0;
        model_latch();
      end
      1, 2: begin
        if (m_cnt == m_per - 1) begin
          adv = (m_split == m_smax);
          if (m_mode == 2 && !ifc.m3start && adv) begin
            m_mode = 0;
          end else begin
            m_cnt = 0;
            if (adv) begin
              m_split = 0;
              m_step  = m_dir ? (m_step + 5) % 6 : (m_step + 1) % 6;
            end else begin
              m_split = m_split + 1;
            end
            model_latch();
            m_mode = ifc.m3start ? 1 : 2;
          end
        end else begin
          m_cnt  = m_cnt + 1;
          m_mode = ifc.m3start ? 1 : 2;
        end
      end
      default: if (!ifc.m3start) m_mode = 0;
    endcase
  endtask

  always @(negedge clk) begin
    bit act;
    if (rst) model_reset();
    act = (m_mode == 1) || (m_mode == 2);
    chk("m3cnt", 32'(ifc.m3cnt), act ? m_cnt : 0);
    chk("first1", 32'(ifc.m3cntFirst1), 32'(act && m_cnt == 0));
    chk("first2", 32'(ifc.m3cntFirst2), 32'(act && m_cnt == 1));
    chk("last1", 32'(ifc.m3cntLast1), 32'(act && m_cnt == m_per - 1));
    chk("last2", 32'(ifc.m3cntLast2), 32'(act && m_cnt == m_per - 2));
    chk("lgStep", 32'(ifc.lgStep), act ? m_step : 15);
    chk("split", 32'(ifc.m3LpwmSplitStep), act ? m_split : 0);
    chk("pwmActive1", 32'(ifc.pwmActive1), 32'(act));
    chk("pwmLastStep1", 32'(ifc.pwmLastStep1), 32'(act && m_split == m_smax));
    chk("m3busy", 32'(ifc.m3busy), 32'(m_mode != 0));
    if (!rst) model_step();
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #10;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200 && ifc.m3busy; i++) cyc(1);
    chk(nm, 32'(ifc.m3busy), 0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    rst = 1'b1;
    ifc.m3start = 1'b0;
    ifc.m3fault = 1'b0;
    ifc.m3r_stepCNT_speedSET = 25'd10;
    ifc.m3r_stepSplitMax = 2'd0;
`ifdef M3SEQ_REVERSE_EN
    ifc.m3r_dirReverse = 1'b0;
`endif
    cyc(3);
    rst = 1'b0;
    chk("rst_lgStep", 32'(ifc.lgStep), 32'hF);
    chk("rst_busy", 32'(ifc.m3busy), 0);
    chk("rst_active", 32'(ifc.pwmActive1), 0);

    // speed 10, splitMax 0: one step every 10 clocks
    ifc.m3start = 1'b1;
    cyc(1);
    chk("start_lgStep", 32'(ifc.lgStep), 0);
    chk("start_cnt", 32'(ifc.m3cnt), 0);
    chk("start_first1", 32'(ifc.m3cntFirst1), 1);
    chk("start_active", 32'(ifc.pwmActive1), 1);
    cyc(8);
    chk("p10_last2", 32'(ifc.m3cntLast2), 1);
    cyc(1);
    chk("p10_last1", 32'(ifc.m3cntLast1), 1);
    cyc(1);
    chk("p10_step1", 32'(ifc.lgStep), 1);
    cyc(49);
    chk("p10_step5", 32'(ifc.lgStep), 5);
    cyc(1);
    chk("p10_wrap0", 32'(ifc.lgStep), 0);

    // speed 2 clamps to 4 from the next wrap onward
    ifc.m3r_stepCNT_speedSET = 25'd2;
    cyc(10);
    chk("clamp_step1", 32'(ifc.lgStep), 1);
    cyc(3);
    chk("clamp_cnt3", 32'(ifc.m3cnt), 3);
    chk("clamp_last1", 32'(ifc.m3cntLast1), 1);
    chk("clamp_laststep", 32'(ifc.pwmLastStep1), 1);
    cyc(9);

    // split 0..2 with speed 5
    ifc.m3r_stepCNT_speedSET = 25'd5;
    ifc.m3r_stepSplitMax = 2'd2;
    cyc(40);
    ifc.m3start = 1'b0;
    wait_idle("split_stop_idle");

    // graceful stop dropped at cnt 3 of step 2
    ifc.m3r_stepCNT_speedSET = 25'd10;
    ifc.m3r_stepSplitMax = 2'd0;
    ifc.m3start = 1'b1;
    cyc(24);
    chk("stop_at_step", 32'(ifc.lgStep), 2);
    chk("stop_at_cnt", 32'(ifc.m3cnt), 3);
    ifc.m3start = 1'b0;
    cyc(6);
    chk("stopping_cnt9", 32'(ifc.m3cnt), 9);
    chk("stopping_active", 32'(ifc.pwmActive1), 1);
    cyc(1);
    chk("stopped_lgStep", 32'(ifc.lgStep), 32'hF);
    chk("stopped_active", 32'(ifc.pwmActive1), 0);
    chk("stopped_busy", 32'(ifc.m3busy), 0);

    // stop then resume before the step ends
    ifc.m3start = 1'b1;
    cyc(5);
    ifc.m3start = 1'b0;
    cyc(2);
    ifc.m3start = 1'b1;
    cyc(15);

    // fault pulse while start stays high
    ifc.m3fault = 1'b1;
    cyc(1);
    ifc.m3fault = 1'b0;
    chk("fault_lgStep", 32'(ifc.lgStep), 32'hF);
    chk("fault_active", 32'(ifc.pwmActive1), 0);
    chk("fault_busy", 32'(ifc.m3busy), 1);
    cyc(5);
    chk("fault_held", 32'(ifc.m3busy), 1);
    ifc.m3start = 1'b0;
    cyc(1);
    chk("fault_exit", 32'(ifc.m3busy), 0);
    ifc.m3start = 1'b1;
    cyc(1);
    chk("restart_lgStep", 32'(ifc.lgStep), 0);

    // asynchronous reset mid-run
    cyc(7);
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(ifc.m3cnt), 0);
    chk("async_rst_lgStep", 32'(ifc.lgStep), 32'hF);
    chk("async_rst_busy", 32'(ifc.m3busy), 0);
    cyc(3);
    rst = 1'b0;
    cyc(12);
    ifc.m3start = 1'b0;
    wait_idle("rst_run_stop_idle");

`ifdef M3SEQ_REVERSE_EN
    ifc.m3r_dirReverse = 1'b1;
    ifc.m3start = 1'b1;
    cyc(1);
    chk("rev_step0", 32'(ifc.lgStep), 0);
    cyc(10);
    chk("rev_step5", 32'(ifc.lgStep), 5);
    cyc(10);
    chk("rev_step4", 32'(ifc.lgStep), 4);
    cyc(40);
    chk("rev_wrap0", 32'(ifc.lgStep), 0);
    ifc.m3start = 1'b0;
    wait_idle("rev_stop_idle");
`endif

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
